// File: rtl/instruction_queue_fifo.sv
// Decoded-instruction FIFO between decode and issue: first-word fall-through,
// back-pressure on full, no bypass when empty.
module instruction_queue_fifo #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic [3:0]  MajorOpcode_in,
   input  logic [4:0]  Source1_in,
   input  logic [4:0]  Source2_in,
   input  logic [1:0]  OffsetScale_in,
   input  logic [4:0]  Destination_in,
   input  logic [3:0]  MinorOpcode_in,
   input  logic        HasAddress_in,
   input  logic [47:0] Address_in,
   input  logic        OffsetSub_in,
   input  logic        stall_in,
   output logic        valid_out,
   output logic [3:0]  MajorOpcode_out,
   output logic [4:0]  Source1_out,
   output logic [4:0]  Source2_out,
   output logic [1:0]  OffsetScale_out,
   output logic [4:0]  Destination_out,
   output logic [3:0]  MinorOpcode_out,
   output logic        HasAddress_out,
   output logic [47:0] Address_out,
   output logic        OffsetSub_out,
   output logic        stall_out
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int EW = 75;

   logic [EW-1:0] mem_q [DEPTH];
   logic [EW-1:0] mem_d [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic [EW-1:0] entry_in_s;
   logic [EW-1:0] head_s;
   logic          full_s;
   logic          empty_s;
   logic          enq_s;
   logic          deq_s;

   // Handshake decode: a full queue refuses enqueue even while draining.
   always_comb begin
      entry_in_s = {MajorOpcode_in, Source1_in, Source2_in, OffsetScale_in, Destination_in,
                    MinorOpcode_in, HasAddress_in, Address_in, OffsetSub_in};
      full_s     = (count_q == CW'(DEPTH));
      empty_s    = (count_q == CW'(0));
      enq_s      = valid_in & ~full_s;
      deq_s      = ~empty_s & ~stall_in;
   end

   // Next-state for pointers, occupancy and storage.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (enq_s) begin
         mem_d[wr_ptr_q] = entry_in_s;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (deq_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({enq_s, deq_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state register; reset discards every queued entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= {AW{1'b0}};
         wr_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage carries no reset; stale contents are masked by the count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Head mux driven from registered state only.
   always_comb begin
      if (empty_s) begin
         head_s = {EW{1'b0}};
      end else begin
         head_s = mem_q[rd_ptr_q];
      end
   end

   assign {MajorOpcode_out, Source1_out, Source2_out, OffsetScale_out, Destination_out,
           MinorOpcode_out, HasAddress_out, Address_out, OffsetSub_out} = head_s;
   assign valid_out = ~empty_s;
   assign stall_out = full_s;

endmodule

// File: tb/tb_instruction_queue_fifo.sv
// Directed self-checking bench for instruction_queue_fifo (DEPTH=8).
module tb_instruction_queue_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic [3:0]  MajorOpcode_in;
   logic [4:0]  Source1_in;
   logic [4:0]  Source2_in;
   logic [1:0]  OffsetScale_in;
   logic [4:0]  Destination_in;
   logic [3:0]  MinorOpcode_in;
   logic        HasAddress_in;
   logic [47:0] Address_in;
   logic        OffsetSub_in;
   logic        stall_in;
   logic        valid_out;
   logic [3:0]  MajorOpcode_out;
   logic [4:0]  Source1_out;
   logic [4:0]  Source2_out;
   logic [1:0]  OffsetScale_out;
   logic [4:0]  Destination_out;
   logic [3:0]  MinorOpcode_out;
   logic        HasAddress_out;
   logic [47:0] Address_out;
   logic        OffsetSub_out;
   logic        stall_out;

   int checks_cnt = 0;
   int errors_cnt = 0;

   logic [74:0] out_bus_s;
   assign out_bus_s = {MajorOpcode_out, Source1_out, Source2_out, OffsetScale_out,
                       Destination_out, MinorOpcode_out, HasAddress_out, Address_out,
                       OffsetSub_out};

   instruction_queue_fifo #(.DEPTH(8)) dut (
      .clk             (clk),
      .rst             (rst),
      .valid_in        (valid_in),
      .MajorOpcode_in  (MajorOpcode_in),
      .Source1_in      (Source1_in),
      .Source2_in      (Source2_in),
      .OffsetScale_in  (OffsetScale_in),
      .Destination_in  (Destination_in),
      .MinorOpcode_in  (MinorOpcode_in),
      .HasAddress_in   (HasAddress_in),
      .Address_in      (Address_in),
      .OffsetSub_in    (OffsetSub_in),
      .stall_in        (stall_in),
      .valid_out       (valid_out),
      .MajorOpcode_out (MajorOpcode_out),
      .Source1_out     (Source1_out),
      .Source2_out     (Source2_out),
      .OffsetScale_out (OffsetScale_out),
      .Destination_out (Destination_out),
      .MinorOpcode_out (MinorOpcode_out),
      .HasAddress_out  (HasAddress_out),
      .Address_out     (Address_out),
      .OffsetSub_out   (OffsetSub_out),
      .stall_out       (stall_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Entry fields derived from the address so every field is exercised.
   function automatic logic [74:0] mk_entry(input logic [47:0] a);
      logic [7:0] b;
      b = a[7:0];
      return {b[3:0] ^ 4'h5, b[4:0], ~b[4:0], b[1:0], b[4:0] ^ 5'h0a,
              ~b[3:0], b[0], a, b[1]};
   endfunction

   task automatic drive(input logic [74:0] e);
      {MajorOpcode_in, Source1_in, Source2_in, OffsetScale_in, Destination_in,
       MinorOpcode_in, HasAddress_in, Address_in, OffsetSub_in} = e;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [74:0] single_e;
      rst      = 1'b1;
      valid_in = 1'b1;
      stall_in = 1'b0;
      drive(mk_entry(48'd77));
      step();
      step();
      check("rst_valid", 80'(valid_out), 80'(1'b0));
      check("rst_stall", 80'(stall_out), 80'(1'b0));
      check("rst_bus",   80'(out_bus_s), 80'(0));

      // Single pass
      rst      = 1'b0;
      single_e = {4'b1010, 5'b11111, 5'b01110, 2'b11, 5'b11011, 4'b1001, 1'b1, 48'd98, 1'b1};
      drive(single_e);
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      check("single_valid", 80'(valid_out), 80'(1'b1));
      check("single_bus",   80'(out_bus_s), 80'(single_e));
      step();
      check("single_empty_valid", 80'(valid_out), 80'(1'b0));
      check("single_empty_bus",   80'(out_bus_s), 80'(0));

      // Fill to full with the consumer stalled
      stall_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(mk_entry(48'(i)));
         valid_in = 1'b1;
         step();
         if (i == 6) check("fill_stall_7", 80'(stall_out), 80'(1'b0));
      end
      check("fill_stall_8", 80'(stall_out), 80'(1'b1));
      drive(mk_entry(48'd8));
      step();
      valid_in = 1'b0;
      check("fill_head_after_9th", 80'(out_bus_s), 80'(mk_entry(48'd0)));
      stall_in = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("fill_drain_valid", 80'(valid_out), 80'(1'b1));
         check("fill_drain_bus",   80'(out_bus_s), 80'(mk_entry(48'(i))));
         step();
      end
      check("fill_drained", 80'(valid_out), 80'(1'b0));

      // Wrap-around: advance pointers by 6, then stream 10 through
      stall_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(mk_entry(48'(200 + i)));
         valid_in = 1'b1;
         step();
      end
      valid_in = 1'b0;
      stall_in = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check("wrap_pre_addr", 80'(Address_out), 80'(200 + i));
         step();
      end
      check("wrap_pre_empty", 80'(valid_out), 80'(1'b0));
      for (int i = 0; i < 10; i++) begin
         drive(mk_entry(48'(100 + i)));
         valid_in = 1'b1;
         step();
         check("wrap_stream_bus", 80'(out_bus_s), 80'(mk_entry(48'(100 + i))));
      end
      valid_in = 1'b0;
      step();
      check("wrap_end_empty", 80'(valid_out), 80'(1'b0));

      // Simultaneous enqueue/dequeue at count=3
      stall_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(mk_entry(48'(300 + i)));
         valid_in = 1'b1;
         step();
      end
      stall_in = 1'b0;
      drive(mk_entry(48'd303));
      step();
      valid_in = 1'b0;
      check("simul_stall", 80'(stall_out), 80'(1'b0));
      for (int i = 1; i < 4; i++) begin
         check("simul_drain", 80'(Address_out), 80'(300 + i));
         step();
      end
      check("simul_empty", 80'(valid_out), 80'(1'b0));

      // Full: dequeue proceeds while enqueue is refused
      stall_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(mk_entry(48'(400 + i)));
         valid_in = 1'b1;
         step();
      end
      check("full_stall", 80'(stall_out), 80'(1'b1));
      stall_in = 1'b0;
      drive(mk_entry(48'd499));
      step();
      valid_in = 1'b0;
      check("full_deq_stall", 80'(stall_out), 80'(1'b0));
      for (int i = 1; i < 8; i++) begin
         check("full_drain", 80'(Address_out), 80'(400 + i));
         step();
      end
      check("full_no_499", 80'(valid_out), 80'(1'b0));

      // Reset mid-operation
      stall_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(mk_entry(48'(500 + i)));
         valid_in = 1'b1;
         step();
      end
      valid_in = 1'b0;
      rst      = 1'b1;
      step();
      rst      = 1'b0;
      check("midrst_valid", 80'(valid_out), 80'(1'b0));
      check("midrst_bus",   80'(out_bus_s), 80'(0));
      drive(mk_entry(48'd55));
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      check("midrst_fresh_valid", 80'(valid_out), 80'(1'b1));
      check("midrst_fresh_bus",   80'(out_bus_s), 80'(mk_entry(48'd55)));

      $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
